avb_cmd_master: RTL and testbench

//  Avalon-MM initiator: turns single commands from PL logic into one Avalon read or write

---
 rtl/avb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_avb_cmd_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avb_cmd_master.sv
// avb_cmd_master: Avalon-MM initiator that turns one PL-side command into a single
// Avalon read or write transfer. It handles waitrequest stalls, waits for
// readdatavalid and abandons the transfer after a timeout. It then returns one
// response over a valid/ready handshake. Only one command is outstanding at a time.
//
// Ports
//   clock, resetn                    clock; synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready is combinational)
//   cmd_write/address/writedata/byteenable   command payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_readdata, rsp_error          read data (0 for writes/timeouts), timeout flag
//   timeout_count                    saturating count of timeouts since reset
//   avb_*                            Avalon-MM initiator signals
module avb_cmd_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_writedata,
    input  logic [3:0]  cmd_byteenable,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_readdata,
    output logic        rsp_error,
    output logic [7:0]  timeout_count,
    output logic [31:0] avb_address,
    output logic [3:0]  avb_byteenable,
    output logic [31:0] avb_writedata,
    output logic        avb_read,
    output logic        avb_write,
    input  logic [31:0] avb_readdata,
    input  logic        avb_readdatavalid,
    input  logic        avb_waitrequest
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t          state;
    logic [TO_W-1:0] counter;

    // Only the idle state accepts a command; held low while reset is asserted.
    assign cmd_ready = (state == S_IDLE) & resetn;

    // Transfer sequencer; every output except cmd_ready is a register here.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= S_IDLE;
            counter        <= '0;
            rsp_valid      <= 1'b0;
            rsp_readdata   <= '0;
            rsp_error      <= 1'b0;
            timeout_count  <= '0;
            avb_address    <= '0;
            avb_byteenable <= '0;
            avb_writedata  <= '0;
            avb_read       <= 1'b0;
            avb_write      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        avb_address    <= cmd_address;
                        avb_byteenable <= cmd_byteenable;
                        avb_writedata  <= cmd_writedata;
                        avb_write      <= cmd_write;
                        avb_read       <= ~cmd_write;
                        counter        <= '0;
                        state          <= S_REQ;
                    end
                end

                S_REQ: begin
                    // A write completes at acceptance, so it beats a coincident timeout.
                    // Read acceptance is not a completion.
                    if (!avb_waitrequest && avb_write) begin
                        avb_write    <= 1'b0;
                        rsp_readdata <= '0;
                        rsp_error    <= 1'b0;
                        state        <= S_RESP;
                    end else if (counter == TO_LAST) begin
                        avb_read     <= 1'b0;
                        avb_write    <= 1'b0;
                        rsp_readdata <= '0;
                        rsp_error    <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state        <= S_RESP;
                    end else begin
                        counter <= counter + TO_W'(1);
                        if (!avb_waitrequest) begin
                            avb_read <= 1'b0;
                            state    <= S_WAIT_RD;
                        end
                    end
                end

                S_WAIT_RD: begin
                    if (avb_readdatavalid) begin
                        rsp_readdata <= avb_readdata;
                        rsp_error    <= 1'b0;
                        state        <= S_RESP;
                    end else if (counter == TO_LAST) begin
                        rsp_readdata <= '0;
                        rsp_error    <= 1'b1;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state        <= S_RESP;
                    end else begin
                        counter <= counter + TO_W'(1);
                    end
                end

                S_RESP: begin
                    // Payload settles one cycle before rsp_valid rises.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avb_cmd_master.sv
// Testbench for avb_cmd_master. Transactions are predicted from transfer-level
// rules: the waitrequest length, the readdatavalid delay and the timeout give
// the latency, the response payload and the timeout count.
module tb_avb_cmd_master;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TO_W    = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_address = '0;
    logic [31:0] cmd_writedata = '0;
    logic [3:0]  cmd_byteenable = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_readdata;
    logic        rsp_error;
    logic [7:0]  timeout_count;
    logic [31:0] avb_address;
    logic [3:0]  avb_byteenable;
    logic [31:0] avb_writedata;
    logic        avb_read;
    logic        avb_write;
    logic [31:0] avb_readdata = '0;
    logic        avb_readdatavalid = 1'b0;
    logic        avb_waitrequest = 1'b0;

    int errors = 0;
    int checks = 0;
    int tc_model = 0;

    avb_cmd_master #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock             (clock),
        .resetn            (resetn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_address       (cmd_address),
        .cmd_writedata     (cmd_writedata),
        .cmd_byteenable    (cmd_byteenable),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_readdata      (rsp_readdata),
        .rsp_error         (rsp_error),
        .timeout_count     (timeout_count),
        .avb_address       (avb_address),
        .avb_byteenable    (avb_byteenable),
        .avb_writedata     (avb_writedata),
        .avb_read          (avb_read),
        .avb_write         (avb_write),
        .avb_readdata      (avb_readdata),
        .avb_readdatavalid (avb_readdatavalid),
        .avb_waitrequest   (avb_waitrequest)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero();
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_readdata", rsp_readdata, 0);
        check_eq("rst_rsp_error", 32'(rsp_error), 0);
        check_eq("rst_timeout_count", 32'(timeout_count), 0);
        check_eq("rst_avb_address", avb_address, 0);
        check_eq("rst_avb_byteenable", 32'(avb_byteenable), 0);
        check_eq("rst_avb_writedata", avb_writedata, 0);
        check_eq("rst_avb_read", 32'(avb_read), 0);
        check_eq("rst_avb_write", 32'(avb_write), 0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    endtask

    // One command: w = waitrequest cycles, l = readdatavalid delay after acceptance
    // (0 = never), hold = cycles rsp_ready stays low once the response is visible.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input int w, input int l,
                           input logic [31:0] rdata, input int hold);
        bit ok;
        int acc;
        int lat;
        int k;
        if (wr) ok = (w + 1 <= int'(TIMEOUT));
        else    ok = (l != 0) && (w + 1 + l <= int'(TIMEOUT));
        acc = (w + 1 < int'(TIMEOUT)) ? w + 1 : int'(TIMEOUT);
        lat = ok ? (wr ? w + 2 : w + l + 2) : int'(TIMEOUT) + 1;

        check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid       = 1'b1;
        cmd_write       = wr;
        cmd_address     = addr;
        cmd_writedata   = data;
        cmd_byteenable  = be;
        avb_waitrequest = (w > 0);
        avb_readdatavalid = 1'b0;
        step();
        cmd_valid      = 1'b0;
        cmd_address    = $urandom;
        cmd_writedata  = $urandom;
        cmd_byteenable = 4'($urandom);
        cmd_write      = 1'($urandom);

        for (int j = 0; j <= lat; j++) begin
            check_eq("cmd_ready_busy", 32'(cmd_ready), 0);
            check_eq("avb_write", 32'(avb_write), 32'(wr && j < acc));
            check_eq("avb_read", 32'(avb_read), 32'(!wr && j < acc));
            if (j < acc) begin
                check_eq("avb_address", avb_address, addr);
                check_eq("avb_byteenable", 32'(avb_byteenable), 32'(be));
                check_eq("avb_writedata", avb_writedata, data);
            end
            check_eq("rsp_valid", 32'(rsp_valid), 32'(j >= lat));
            if (j < lat) begin
                k = j + 1;
                if (k <= w) avb_waitrequest = 1'b1;
                else if (k == w + 1) avb_waitrequest = 1'b0;
                else avb_waitrequest = 1'($urandom);
                if (!wr && l != 0 && k == w + 1 + l) begin
                    avb_readdatavalid = 1'b1;
                    avb_readdata      = rdata;
                end else if (wr || k <= w + 1) begin
                    avb_readdatavalid = 1'($urandom);
                    avb_readdata      = $urandom;
                end else begin
                    avb_readdatavalid = 1'b0;
                    avb_readdata      = $urandom;
                end
                step();
            end
        end

        if (!ok && tc_model < 255) tc_model++;
        check_eq("rsp_readdata", rsp_readdata, (ok && !wr) ? rdata : 32'h0);
        check_eq("rsp_error", 32'(rsp_error), 32'(!ok));
        check_eq("timeout_count", 32'(timeout_count), 32'(tc_model));

        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            avb_readdatavalid = 1'($urandom);
            avb_readdata      = $urandom;
            avb_waitrequest   = 1'($urandom);
            step();
            check_eq("rsp_hold_valid", 32'(rsp_valid), 1);
            check_eq("rsp_hold_cmd_ready", 32'(cmd_ready), 0);
            check_eq("rsp_hold_readdata", rsp_readdata, (ok && !wr) ? rdata : 32'h0);
            check_eq("rsp_hold_error", 32'(rsp_error), 32'(!ok));
            check_eq("rsp_hold_strobes", 32'({avb_read, avb_write}), 0);
        end
        rsp_ready = 1'b1;
        avb_readdatavalid = 1'b0;
        step();
        rsp_ready = 1'b0;
        check_eq("rsp_done_valid", 32'(rsp_valid), 0);
        check_eq("rsp_done_cmd_ready", 32'(cmd_ready), 1);
    endtask

    // Both strobes must never be high together.
    always @(negedge clock) begin
        if (resetn && avb_read && avb_write) begin
            check_eq("strobe_exclusive", 32'({avb_read, avb_write}), 32'b01);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit wr;
        int w;
        int l;
        // Reset state
        resetn = 1'b0;
        step();
        step();
        check_all_zero();
        resetn = 1'b1;
        #1;
        check_eq("cmd_ready_after_rst", 32'(cmd_ready), 1);
        step();

        // 1: zero-wait write
        run_txn(1'b1, 32'h0, 32'h10, 4'hF, 0, 0, 32'h0, 0);
        // 2: read with 1-cycle readdatavalid
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 1, 32'h0000FFF6, 0);
        // 3: write stalled 5 cycles
        run_txn(1'b1, 32'h8, 32'hA5A5_0001, 4'h3, 5, 0, 32'h0, 0);
        // 4: read timeout, late data during the held response
        run_txn(1'b0, 32'hC, 32'h0, 4'hF, 0, 0, 32'h0, 3);
        // Spurious readdatavalid while idle has no effect
        avb_readdatavalid = 1'b1;
        avb_readdata = 32'hDEAD_BEEF;
        step();
        step();
        avb_readdatavalid = 1'b0;
        check_eq("idle_spurious_rsp_valid", 32'(rsp_valid), 0);
        check_eq("idle_spurious_cmd_ready", 32'(cmd_ready), 1);
        // Boundaries: write accepted on the timeout edge; read data on the timeout edge
        run_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, int'(TIMEOUT) - 1, 0, 32'h0, 0);
        run_txn(1'b0, 32'h14, 32'h0, 4'hF, 2, int'(TIMEOUT) - 3, 32'hCAFE_0001, 0);
        run_txn(1'b0, 32'h18, 32'h0, 4'hF, 2, int'(TIMEOUT) - 2, 32'hCAFE_0002, 0);
        run_txn(1'b1, 32'h1C, 32'h0, 4'hF, int'(TIMEOUT), 0, 32'h0, 0);
        // 5: response held 10 cycles, then back-to-back commands
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1, 2, 32'h0BAD_F00D, 10);
        run_txn(1'b1, 32'h24, 32'h5555_AAAA, 4'hC, 0, 0, 32'h0, 0);
        run_txn(1'b0, 32'h28, 32'h0, 4'h1, 0, 1, 32'h1357_9BDF, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
            l  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(0, 6));
            run_txn(wr, $urandom, $urandom, 4'($urandom), w, l, $urandom, int'($urandom_range(0, 3)));
        end

        // 6: reset during WAIT_RD
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 32'h30;
        cmd_byteenable = 4'hF;
        avb_waitrequest = 1'b0;
        avb_readdatavalid = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_eq("wait_rd_strobe", 32'({avb_read, avb_write}), 0);
        resetn = 1'b0;
        step();
        check_all_zero();
        avb_readdatavalid = 1'b1;
        avb_readdata = 32'h7777_7777;
        resetn = 1'b1;
        #1;
        tc_model = 0;
        check_eq("cmd_ready_release", 32'(cmd_ready), 1);
        step();
        avb_readdatavalid = 1'b0;
        check_eq("post_rst_rsp_valid", 32'(rsp_valid), 0);
        run_txn(1'b0, 32'h34, 32'h0, 4'hF, 0, 1, 32'h2468_ACE0, 0);

        // Saturation of timeout_count
        for (int n = 0; n < 258; n++) begin
            run_txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 32'h0, 0);
        end
        check_eq("timeout_count_sat", 32'(timeout_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
